// File: rtl/fp_stream_pattern_src.sv
// Purpose : AXI-Stream test-pattern source for floating-point core bring-up; emits packets of
//           PKT_LEN beats, tdata = {packet, beat}, tuser from a generated sideband ROM.
// Latency : first m_tvalid two cycles after the start pulse, then one beat per cycle.
// Backpressure: m_tdata/m_tuser/m_tlast held while m_tvalid & !m_tready; no bubbles with m_tready high.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, stop         run control pulses (start ignored while busy, stop sticky until run end)
//   num_pkts            packets per run, sampled on start (0 = run until stop)
//   m_t*                AXI-Stream master (tdata, tuser, tlast, tvalid, tready)
//   busy, done, pkt_cnt run status; done pulses once per run, pkt_cnt counts completed packets
// Optional: FP_STREAM_PATTERN_SRC_ERR_INJ_EN adds err_inj/err_done for sign-bit corruption
//           of the next tlast beat.
module fp_stream_pattern_src #(
    parameter int DATA_W  = 32,
    parameter int TUSER_W = 8,
    parameter int ADDR_W  = 4,
    parameter int PKT_LEN = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [15:0]        num_pkts,
    output logic [DATA_W-1:0]  m_tdata,
    output logic [TUSER_W-1:0] m_tuser,
    output logic               m_tlast,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               busy,
    output logic               done,
    output logic [15:0]        pkt_cnt
`ifdef FP_STREAM_PATTERN_SRC_ERR_INJ_EN
    ,
    input  logic               err_inj,
    output logic               err_done
`endif
);

    localparam int H     = TUSER_W / 2;
    localparam int HD    = DATA_W / 2;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_B     = ADDR_W'(PKT_LEN - 1);
    // Beat following beat 0; wraps straight back to 0 for single-beat packets.
    localparam logic [ADDR_W-1:0] FIRST_NEXT = (PKT_LEN > 1) ? ADDR_W'(1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t state;

    // Sideband ROM contents: {beats remaining after this one, beat index}.
    logic [TUSER_W-1:0] rom [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        if (gi < PKT_LEN) begin : g_used
            assign rom[gi] = {H'(PKT_LEN - 1 - gi), H'(gi)};
        end else begin : g_unused
            assign rom[gi] = '0;
        end
    end

    logic [ADDR_W-1:0]  beat_idx;   // beat currently presented on the output
    logic [HD-1:0]      pkt_idx;    // packet currently presented on the output
    logic [TUSER_W-1:0] rom_q;      // prefetched sideband of the beat after the output beat
    logic [15:0]        num_lat;
    logic               stop_flag;

    logic               beat_last;
    logic [ADDR_W-1:0]  nb;
    logic [ADDR_W-1:0]  nnb;
    logic [HD-1:0]      np;
    logic               hs;
    logic [15:0]        cnt_inc;
    logic               run_end;
    logic               priming;
    logic               ld_en;
    logic [ADDR_W-1:0]  ld_b;
    logic [HD-1:0]      ld_p;
    logic [TUSER_W-1:0] ld_user;
    logic [ADDR_W-1:0]  pf_addr;
    logic               ld_last;
    logic               ld_corrupt;
    logic [DATA_W-1:0]  ld_data;

    assign beat_last = (beat_idx == LAST_B);
    assign nb        = beat_last ? '0 : beat_idx + 1'b1;
    assign np        = beat_last ? pkt_idx + 1'b1 : pkt_idx;
    assign nnb       = (nb == LAST_B) ? '0 : nb + 1'b1;
    assign hs        = m_tvalid & m_tready;
    assign cnt_inc   = pkt_cnt + 16'd1;
    // A pending or same-cycle stop only takes effect on a packet boundary.
    assign run_end   = beat_last &
                       (((num_lat != 16'd0) && (cnt_inc == num_lat)) | stop_flag | stop);
    assign priming   = (state == ST_PRIME);

    // The output register is loaded either when priming (beat 0, read straight from the ROM)
    // or on a handshake that does not end the run (next beat, sideband from the prefetch reg).
    assign ld_en   = priming | ((state == ST_STREAM) & hs & ~run_end);
    assign ld_b    = priming ? '0 : nb;
    assign ld_p    = priming ? '0 : np;
    assign ld_user = priming ? rom[0] : rom_q;
    assign pf_addr = priming ? FIRST_NEXT : nnb;
    assign ld_last = (ld_b == LAST_B);
    assign ld_data = {ld_p, HD'(ld_b)} ^ {ld_corrupt, {(DATA_W-1){1'b0}}};

`ifdef FP_STREAM_PATTERN_SRC_ERR_INJ_EN
    logic err_arm;    // request waiting for the next tlast beat
    logic err_beat;   // beat on the output carries the corruption
    logic armed_for_load;

    // The request is consumed by the handshake of the corrupted beat, so a beat loaded in
    // that same cycle must not see it again (matters for single-beat packets).
    assign armed_for_load = (err_arm & ~(hs & err_beat)) | err_inj;
    assign ld_corrupt     = ld_last & armed_for_load;
    assign err_done       = hs & err_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_arm  <= 1'b0;
            err_beat <= 1'b0;
        end else begin
            if (err_inj) begin
                err_arm <= 1'b1;
            end else if (hs && err_beat) begin
                err_arm <= 1'b0;
            end
            if (ld_en) begin
                err_beat <= ld_corrupt;
            end else if (hs) begin
                err_beat <= 1'b0;
            end
        end
    end
`else
    assign ld_corrupt = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tuser   <= '0;
            m_tlast   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pkt_cnt   <= '0;
            beat_idx  <= '0;
            pkt_idx   <= '0;
            rom_q     <= '0;
            num_lat   <= '0;
            stop_flag <= 1'b0;
        end else begin
            done <= 1'b0;

            if (ld_en) begin
                m_tvalid <= 1'b1;
                m_tdata  <= ld_data;
                m_tuser  <= ld_user;
                m_tlast  <= ld_last;
                beat_idx <= ld_b;
                pkt_idx  <= ld_p;
                rom_q    <= rom[pf_addr];
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_PRIME;
                        busy      <= 1'b1;
                        num_lat   <= num_pkts;
                        pkt_cnt   <= '0;
                        stop_flag <= 1'b0;
                    end
                end
                ST_PRIME: begin
                    state <= ST_STREAM;
                    if (stop) stop_flag <= 1'b1;
                end
                ST_STREAM: begin
                    if (stop) stop_flag <= 1'b1;
                    if (hs) begin
                        if (beat_last) pkt_cnt <= cnt_inc;
                        if (run_end) begin
                            m_tvalid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_stream_pattern_src.sv
// Scoreboard bench for fp_stream_pattern_src with default parameters: stimulus pushes the
// expected beats into a queue, a negedge monitor pops and compares on every handshake
// and checks that outputs hold while stalled.
module tb_fp_stream_pattern_src;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] num_pkts;
    logic [31:0] m_tdata;
    logic [7:0]  m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        busy;
    logic        done;
    logic [15:0] pkt_cnt;
`ifdef FP_STREAM_PATTERN_SRC_ERR_INJ_EN
    logic        err_inj;
    logic        err_done;
`endif

    fp_stream_pattern_src dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .num_pkts (num_pkts),
        .m_tdata  (m_tdata),
        .m_tuser  (m_tuser),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .busy     (busy),
        .done     (done),
        .pkt_cnt  (pkt_cnt)
`ifdef FP_STREAM_PATTERN_SRC_ERR_INJ_EN
        ,
        .err_inj  (err_inj),
        .err_done (err_done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  u;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks     = 0;
    int    n_fail       = 0;
    int    done_cnt     = 0;
    int    err_done_cnt = 0;
    int    rdy_mode     = 1;   // 0 low, 1 high, 2 random
    bit    prev_stall   = 1'b0;
    beat_t prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int p, input int b);
        beat_t t;
        t.d = {p[15:0], b[15:0]};
        t.u = {4'(9 - b), 4'(b)};
        t.l = (b == 9);
        return t;
    endfunction

    task automatic push_run(input int npk);
        for (int p = 0; p < npk; p++)
            for (int b = 0; b < 10; b++)
                exp_q.push_back(mk(p, b));
    endtask

    // Ready driver, changes just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_tvalid", 32'(m_tvalid), 32'd1);
                check("stall_tdata", m_tdata, prev.d);
                check("stall_tuser", 32'(m_tuser), 32'(prev.u));
                check("stall_tlast", 32'(m_tlast), 32'(prev.l));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got tdata 0x%0h, required no beat", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_tdata", m_tdata, e.d);
                    check("beat_tuser", 32'(m_tuser), 32'(e.u));
                    check("beat_tlast", 32'(m_tlast), 32'(e.l));
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev.d = m_tdata;
            prev.u = m_tuser;
            prev.l = m_tlast;
        end
        if (done) done_cnt++;
`ifdef FP_STREAM_PATTERN_SRC_ERR_INJ_EN
        if (err_done) err_done_cnt++;
`endif
    end

    task automatic start_run(input int n);
        @(posedge clk);
        #1;
        num_pkts = 16'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int i;
        i = 0;
        while (done_cnt == base && i < budget) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        check("done_once", 32'(done_cnt), 32'(base + 1));
    endtask

    task automatic wait_beat(input logic [31:0] v, input int budget);
        int i;
        i = 0;
        @(negedge clk);
        while (!(m_tvalid && m_tdata == v) && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (!(m_tvalid && m_tdata == v)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_beat: tdata 0x%0h never presented, last 0x%0h", v, m_tdata);
        end
    endtask

    task automatic end_checks(input string tag, input int npk);
        check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(npk));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required run completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        num_pkts = '0;
`ifdef FP_STREAM_PATTERN_SRC_ERR_INJ_EN
        err_inj = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_tuser", 32'(m_tuser), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // stop while idle is ignored
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        check("idle_stop_busy", 32'(busy), 32'd0);
        check("idle_stop_tvalid", 32'(m_tvalid), 32'd0);

        // Single packet, latency and content
        base = done_cnt;
        push_run(1);
        @(posedge clk);
        #1;
        num_pkts = 16'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_tvalid_cycle1", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        check("t1_tvalid_cycle2", 32'(m_tvalid), 32'd1);
        wait_done(base, 100);
        end_checks("t1", 1);

        // Three packets back to back, no gaps
        base = done_cnt;
        push_run(3);
        start_run(3);
        n = 0;
        while (!m_tvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (m_tvalid && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("t2_gapless_beats", 32'(n), 32'd30);
        wait_done(base, 100);
        end_checks("t2", 3);

        // Two packets with random backpressure, start while busy ignored
        base = done_cnt;
        rdy_mode = 2;
        push_run(2);
        start_run(2);
        repeat (5) @(negedge clk);
        start_run(5);
        wait_done(base, 400);
        end_checks("t3", 2);
        rdy_mode = 1;

        // Free run stopped during packet 5 beat 4
        base = done_cnt;
        push_run(6);
        start_run(0);
        wait_beat(32'h0005_0004, 200);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_done(base, 100);
        end_checks("t4", 6);

        // Stop coincident with the tlast handshake
        base = done_cnt;
        push_run(2);
        start_run(0);
        wait_beat(32'h0001_0009, 100);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_done(base, 100);
        end_checks("t5", 2);

        // Reset mid-packet, then restart
        push_run(1);
        start_run(1);
        wait_beat(32'h0000_0006, 50);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_tvalid", 32'(m_tvalid), 32'd0);
        check("t6_rst_tdata", m_tdata, 32'd0);
        check("t6_rst_tuser", 32'(m_tuser), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = done_cnt;
        push_run(1);
        start_run(1);
        wait_done(base, 100);
        end_checks("t6", 1);

`ifdef FP_STREAM_PATTERN_SRC_ERR_INJ_EN
        // Sign-bit corruption of the next tlast beat
        begin
            beat_t t;
            int    ebase;
            for (int p = 0; p < 2; p++)
                for (int b = 0; b < 10; b++) begin
                    t = mk(p, b);
                    if (p == 0 && b == 9) t.d = 32'h8000_0009;
                    exp_q.push_back(t);
                end
            base = done_cnt;
            ebase = err_done_cnt;
            start_run(2);
            wait_beat(32'h0000_0003, 50);
            err_inj = 1'b1;
            @(posedge clk);
            #1;
            err_inj = 1'b0;
            wait_done(base, 100);
            end_checks("t7", 2);
            check("t7_err_done", 32'(err_done_cnt), 32'(ebase + 1));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_stream_pattern_src.md
Name: fp_stream_pattern_src

Overview:
- Parametrised AXI-Stream test-pattern source for onboard floating-point core bring-up.
- Replaces the fixed 10-entry tuser byte table with a generated per-beat sideband ROM, configurable packet length, and a packet-count/loop controller.
- Full tvalid/tready backpressure with sustained 1 beat/cycle throughput.
- Sits upstream of the flt_pds2 core input on the onboard tlast/tuser test harness.

Parameters:
- DATA_W, 32, tdata width; even, ≥8.
- TUSER_W, 8, tuser width; even, ≥2.
- ADDR_W, 4, ROM address width; depth = 2^ADDR_W.
- PKT_LEN, 10, beats per packet; 1 ≤ PKT_LEN ≤ 2^ADDR_W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- stop  in  1  pulse; ends the run after the current packet's tlast
- num_pkts  in  16  packets per run, sampled on start; 0 = run until stop
- m_tdata  out  DATA_W  beat data
- m_tuser  out  TUSER_W  beat sideband from ROM
- m_tlast  out  1  last beat of packet
- m_tvalid  out  1  beat valid
- m_tready  in  1  downstream ready
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after the final beat handshake
- pkt_cnt  out  16  completed packets in the current run; wraps at 2^16

Behaviour:
- Reset (asynchronous, any state): m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, busy=0, done=0, pkt_cnt=0.
- Reset also clears internal beat index, packet index, stop flag and prefetch buffer.
- Sideband ROM: registered read, 1-cycle latency. H = TUSER_W/2.
  - Entry i < PKT_LEN holds {(PKT_LEN-1-i)[H-1:0], i[H-1:0]}.
  - Entries ≥ PKT_LEN hold 0 and are never addressed.
- Beat content, beat b of packet p:
  - m_tdata = {p[DATA_W/2-1:0], b[DATA_W/2-1:0]}
  - m_tuser = ROM[b]
  - m_tlast = (b == PKT_LEN-1)
- FSM states:
  - IDLE: start=1 → PRIME; busy=1; latch num_pkts; clear pkt_cnt; clear stop flag.
  - PRIME: issue ROM read of beat 0 → STREAM. First m_tvalid is asserted 2 cycles after the start pulse.
  - STREAM: a handshake is m_tvalid & m_tready.
    - On handshake: advance beat index; on tlast beat, increment packet index and pkt_cnt, and reset beat index to 0.
    - Run ends on the tlast handshake when pkt_cnt+1 == latched num_pkts (num_pkts≠0), or when the stop flag is set → DONE.
  - DONE: done=1 for one cycle, busy=0, m_tvalid=0 → IDLE.
- Handshake rules:
  - While m_tvalid=1 and m_tready=0, m_tdata, m_tuser and m_tlast hold stable.
  - m_tvalid never drops without a handshake.
  - With m_tready held high, one beat per cycle, no bubbles, including across packet boundaries. The sync ROM must therefore be prefetched: a 2-entry skid buffer or equivalent.
- Boundary conditions:
  - start while busy: ignored.
  - stop while IDLE: ignored.
  - stop in the same cycle as a tlast handshake: run ends on that beat.
  - stop pulses are latched (sticky until run end).
  - PKT_LEN=1: every beat has tlast=1 and tuser = 0.
  - Packet index wraps at 2^(DATA_W/2) and pkt_cnt wraps at 2^16, both silently.

Optional Feature:
- Macro: FP_STREAM_PATTERN_SRC_ERR_INJ_EN.
- Defined:
  - Adds input err_inj (1 bit), a pulse that arms a sticky flag.
  - The next tlast beat emitted has m_tdata[DATA_W-1] inverted (sign-bit corruption); the flag clears on that beat's handshake.
  - Adds output err_done (1 bit), a pulse on that handshake.
  - Reset clears the flag.
- Undefined: no err_inj/err_done ports; data always per formula.

Test Plan:
- Defaults, num_pkts=1, m_tready=1, start pulse → m_tvalid rises 2 cycles later; 10 beats with tuser 0x90,0x81,…,0x09, tdata 0x00000000..0x00000009, tlast only on beat 9; done pulses once; pkt_cnt=1.
- num_pkts=3, m_tready=1 → 30 consecutive valid cycles with no gaps; beat 0 of packet 2 has tdata=0x00020000, tuser=0x90; pkt_cnt=3.
- num_pkts=2, m_tready pseudo-random at 50% → outputs stable across every stall; beat sequence identical to the no-stall run; no beat lost or duplicated.
- num_pkts=0, stop pulse during beat 4 of packet 5 → stream continues to packet 5 beat 9 (tlast); done pulses; pkt_cnt=6.
- rst asserted mid-packet (beat 6) → outputs cleared asynchronously; next start restarts at tdata=0x00000000, tuser=0x90.
- FP_STREAM_PATTERN_SRC_ERR_INJ_EN defined, err_inj pulse during beat 3 → beat 9 tdata=0x80000009, err_done pulse; next packet's beat 9 tdata=0x00010009.
